vga_timing_gen: RTL and testbench

// - Upstream timing source for the VGA path: divides the system clock to a pixel-enable tick.
// - Runs the horizontal/vertical scan counters (count_h, count_v) that feed the H/V sync comparators.
// - Decodes sync, active-video, pixel coordinates and frame/line strobes from those counters.
// - Default timing is 640x480@60 with sync first: sync, back porch, active, front porch.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_timing_gen_mod_counter.sv | 35 +++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and total-period helpers shared by the
// VGA timing generator and its counter building block.
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_W        = 10;

  typedef logic [DEF_W-1:0] vga_coord_t;

  function automatic int unsigned h_total(input int unsigned sync, input int unsigned bp,
                                          input int unsigned act, input int unsigned fp);
    return sync + bp + act + fp;
  endfunction

  function automatic int unsigned v_total(input int unsigned sync, input int unsigned bp,
                                          input int unsigned act, input int unsigned fp);
    return sync + bp + act + fp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-N counter: advances on inc, wraps MODULUS-1 -> 0, and exposes the
// value it will hold after this clock so callers can register decodes early.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MODULUS = 2,
  parameter int unsigned W       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic [W-1:0] value_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  always_comb begin
    wrap       = inc && (value == LAST);
    value_next = value;
    if (inc) begin
      value_next = wrap ? '0 : value + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, H/V scan counters, and registered
// sync / active-video / coordinate / strobe decode aligned with the counts.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned W        = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic         pix_en,
  output logic [W-1:0] count_h,
  output logic [W-1:0] count_v,
  output logic         h_sync_n,
  output logic         v_sync_n,
  output logic         video_on,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] pix_y,
  output logic         line_end,
  output logic         frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int unsigned V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam int unsigned H_ACT_LO = H_SYNC + H_BP;
  localparam int unsigned H_ACT_HI = H_SYNC + H_BP + H_ACTIVE;
  localparam int unsigned V_ACT_LO = V_SYNC + V_BP;
  localparam int unsigned V_ACT_HI = V_SYNC + V_BP + V_ACTIVE;

  logic [DIV_W-1:0] div, div_next;
  logic             div_wrap;
  logic             div_unused;
  logic             pix_en_r;
  logic             tick;
  logic [W-1:0]     h_next, v_next;
  logic             h_wrap, v_wrap;
  logic             h_act, v_act;

  mod_counter #(.MODULUS(CLK_DIV), .W(DIV_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (en),
    .value     (div),
    .value_next(div_next),
    .wrap      (div_wrap)
  );

  // Only the divider's wrap matters; its count is internal bookkeeping.
  assign div_unused = ^{div, div_next};

  assign tick   = pix_en_r & en;
  assign pix_en = tick;

  mod_counter #(.MODULUS(H_TOTAL), .W(W)) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (tick),
    .value     (count_h),
    .value_next(h_next),
    .wrap      (h_wrap)
  );

  mod_counter #(.MODULUS(V_TOTAL), .W(W)) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (h_wrap),
    .value     (count_v),
    .value_next(v_next),
    .wrap      (v_wrap)
  );

  assign h_act = (32'(h_next) >= H_ACT_LO) && (32'(h_next) < H_ACT_HI);
  assign v_act = (32'(v_next) >= V_ACT_LO) && (32'(v_next) < V_ACT_HI);

  // Decode from next counts so every output lines up with the count it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_r    <= 1'b0;
      h_sync_n    <= 1'b0;
      v_sync_n    <= 1'b0;
      video_on    <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (en) begin
        pix_en_r <= div_wrap;
      end
      h_sync_n    <= (32'(h_next) >= H_SYNC);
      v_sync_n    <= (32'(v_next) >= V_SYNC);
      video_on    <= h_act & v_act;
      pix_x       <= (h_act & v_act) ? h_next - W'(H_ACT_LO) : '0;
      pix_y       <= (h_act & v_act) ? v_next - W'(V_ACT_LO) : '0;
      line_end    <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable scoreboard bench for vga_timing_gen on a shrunken raster,
// with expectations derived from elapsed enabled clocks and pixel ticks.
module tb_vga_timing_gen;

  localparam int unsigned D  = 2;
  localparam int unsigned HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int unsigned VS = 2, VB = 2, VA = 5, VF = 1;
  localparam int unsigned W  = 6;
  localparam int unsigned HT = HS + HB + HA + HF;
  localparam int unsigned VT = VS + VB + VA + VF;
  localparam int NCYC = 1500;

  typedef struct packed {
    logic         pe;
    logic [W-1:0] h;
    logic [W-1:0] v;
    logic         hs_n;
    logic         vs_n;
    logic         vid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         le;
    logic         fs;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         pix_en;
  logic [W-1:0] count_h, count_v, pix_x, pix_y;
  logic         h_sync_n, v_sync_n, video_on, line_end, frame_start;

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: enabled clocks since reset, pixel ticks since reset,
  // and whether the most recent clock edge was a pixel tick.
  longint unsigned k, t;
  bit              last_tick;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(D), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF), .W(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pix_en     (pix_en),
    .count_h    (count_h),
    .count_v    (count_v),
    .h_sync_n   (h_sync_n),
    .v_sync_n   (v_sync_n),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .line_end   (line_end),
    .frame_start(frame_start)
  );

  function automatic bit tick_armed();
    return (k > 0) && (k % D == 0);
  endfunction

  task automatic model_edge(input logic en_then);
    bit tk;
    if (en_then) begin
      tk = tick_armed();
      if (tk) t++;
      k++;
      last_tick = tk;
    end else begin
      last_tick = 1'b0;
    end
  endtask

  task automatic model_reset();
    k = 0;
    t = 0;
    last_tick = 1'b0;
  endtask

  function automatic obs_t expect_now(input logic en_now);
    obs_t        e;
    int unsigned h, v;
    bit          act;
    h   = int'(t % HT);
    v   = int'((t / HT) % VT);
    act = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    e.pe   = en_now && tick_armed();
    e.h    = W'(h);
    e.v    = W'(v);
    e.hs_n = (h >= HS);
    e.vs_n = (v >= VS);
    e.vid  = act;
    e.x    = act ? W'(h - (HS + HB)) : '0;
    e.y    = act ? W'(v - (VS + VB)) : '0;
    e.le   = last_tick && (h == 0);
    e.fs   = last_tick && (h == 0) && (v == 0);
    return e;
  endfunction

  // Stimulus: drive inputs just after each rising edge, push the expected view.
  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back(expect_now(en));
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (rst_n) model_edge(en);
      #1;
      if (c == 700) begin
        rst_n = 1'b0;
        model_reset();
      end else if (c == 703) begin
        rst_n = 1'b1;
      end
      if (c >= 400 && c < 410) en = 1'b0;
      else                     en = ($urandom_range(0, 7) != 0);
      q.push_back(expect_now(en));
    end
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: outputs are valid every clock; compare on the falling edge.
  always @(negedge clk) begin
    obs_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pix_en, count_h, count_v, h_sync_n, v_sync_n, video_on, pix_x, pix_y,
           line_end, frame_start};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got pe=%0b h=%0d v=%0d hs_n=%0b vs_n=%0b vid=%0b x=%0d y=%0d le=%0b fs=%0b | need pe=%0b h=%0d v=%0d hs_n=%0b vs_n=%0b vid=%0b x=%0d y=%0d le=%0b fs=%0b",
                 vectors, a.pe, a.h, a.v, a.hs_n, a.vs_n, a.vid, a.x, a.y, a.le, a.fs,
                 e.pe, e.h, e.v, e.hs_n, e.vs_n, e.vid, e.x, e.y, e.le, e.fs);
      end
    end
  end

endmodule
